cdf_engine: RTL and testbench

//  Histogram-equalization CDF stage. On cdf_start it walks one histogram bank bin by bin and writes the

---
 rtl/cdf_engine.sv | 144 ++++++++++++++
 tb/tb_cdf_engine.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cdf_engine.sv
// Histogram-equalization CDF stage: walks one histogram bank, writes the running sum to the
// matching CDF bank, clears each bin behind it and reports the first non-zero CDF value.
module cdf_engine #(
   parameter int BINS   = 256,
   parameter int ADDR_W = 8,
   parameter int HIST_W = 20
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cdf_start,
   input  logic              base_offset,
   output logic              hist_rd_en,
   output logic [ADDR_W:0]   hist_rd_addr,
   input  logic [HIST_W-1:0] hist_rd_data,
   output logic              hist_wr_en,
   output logic [ADDR_W:0]   hist_wr_addr,
   output logic [HIST_W-1:0] hist_wr_data,
   output logic              cdf_wr_en,
   output logic [ADDR_W:0]   cdf_wr_addr,
   output logic [HIST_W-1:0] cdf_wr_data,
   output logic [HIST_W-1:0] Cdf_Min,
   output logic              cdf_valid,
   output logic              cdf_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(BINS - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q;
   logic                bank_q;
   logic                vld_q;
   logic [ADDR_W:0]     wr_addr_q;
   logic [HIST_W-1:0]   acc_q, acc_d;
   logic [HIST_W-1:0]   min_run_q, min_run_d;
   logic                min_found_q, min_found_d;
   logic [HIST_W-1:0]   cdf_min_q;
   logic                valid_q;
   logic                done_q;
   logic                rd_en_s;
   logic [ADDR_W:0]     rd_addr_s;
   logic [HIST_W:0]     sum_s;
   logic                accept_s;

   assign accept_s = (state_q == ST_IDLE) && cdf_start;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = cdf_start ? ST_RUN : ST_IDLE;
         ST_RUN:   state_d = (cnt_q == LAST_BIN) ? ST_DRAIN : ST_RUN;
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = cdf_start ? ST_DONE : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_en_s   = (state_q == ST_RUN);
      rd_addr_s = rd_en_s ? {bank_q, cnt_q} : {(ADDR_W+1){1'b0}};
   end

   // Saturating accumulate and first-non-zero capture for the bin whose data is returning now.
   always_comb begin
      sum_s       = {1'b0, acc_q} + {1'b0, hist_rd_data};
      acc_d       = sum_s[HIST_W] ? {HIST_W{1'b1}} : sum_s[HIST_W-1:0];
      min_run_d   = min_run_q;
      min_found_d = min_found_q;
      if (vld_q && !min_found_q && (acc_d != {HIST_W{1'b0}})) begin
         min_run_d   = acc_d;
         min_found_d = 1'b1;
      end else begin
         min_run_d   = min_run_q;
         min_found_d = min_found_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q       <= '0;
         bank_q      <= 1'b0;
         vld_q       <= 1'b0;
         wr_addr_q   <= '0;
         acc_q       <= '0;
         min_run_q   <= '0;
         min_found_q <= 1'b0;
         cdf_min_q   <= '0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         vld_q     <= rd_en_s;
         wr_addr_q <= rd_addr_s;
         valid_q   <= (state_q == ST_DRAIN);
         if (accept_s) begin
            bank_q      <= base_offset;
            cnt_q       <= '0;
            acc_q       <= '0;
            min_run_q   <= '0;
            min_found_q <= 1'b0;
            done_q      <= 1'b0;
         end else begin
            if (rd_en_s) begin
               cnt_q <= cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (vld_q) begin
               acc_q       <= acc_d;
               min_run_q   <= min_run_d;
               min_found_q <= min_found_d;
            end
            if (state_q == ST_DRAIN) begin
               cdf_min_q <= min_run_d;
               done_q    <= 1'b1;
            end
         end
      end
   end

   assign hist_rd_en   = rd_en_s;
   assign hist_rd_addr = rd_addr_s;
   assign hist_wr_en   = vld_q;
   assign hist_wr_addr = wr_addr_q;
   assign hist_wr_data = {HIST_W{1'b0}};
   assign cdf_wr_en    = vld_q;
   assign cdf_wr_addr  = wr_addr_q;
   assign cdf_wr_data  = vld_q ? acc_d : {HIST_W{1'b0}};
   assign Cdf_Min      = cdf_min_q;
   assign cdf_valid    = valid_q;
   assign cdf_done     = done_q;

endmodule

// File: tb/tb_cdf_engine.sv
// Randomized self-checking bench for cdf_engine: behavioural RAMs plus a plain-arithmetic CDF model.
module tb_cdf_engine;

   localparam int BINS = 256;
   localparam int HW   = 20;
   localparam longint SAT = (64'd1 << HW) - 64'd1;

   logic          clock = 1'b0;
   logic          reset, cdf_start, base_offset;
   logic          hist_rd_en, hist_wr_en, cdf_wr_en, cdf_valid, cdf_done;
   logic [8:0]    hist_rd_addr, hist_wr_addr, cdf_wr_addr;
   logic [HW-1:0] hist_rd_data, hist_wr_data, cdf_wr_data, Cdf_Min;

   logic [HW-1:0] hist_mem [512];
   logic [HW-1:0] cdf_mem  [512];

   int n_vec = 0;
   int n_err = 0;

   cdf_engine dut (
      .clock(clock), .reset(reset), .cdf_start(cdf_start), .base_offset(base_offset),
      .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data),
      .hist_wr_en(hist_wr_en), .hist_wr_addr(hist_wr_addr), .hist_wr_data(hist_wr_data),
      .cdf_wr_en(cdf_wr_en), .cdf_wr_addr(cdf_wr_addr), .cdf_wr_data(cdf_wr_data),
      .Cdf_Min(Cdf_Min), .cdf_valid(cdf_valid), .cdf_done(cdf_done)
   );

   always #5 clock = ~clock;

   // Synchronous RAM models, one-cycle read latency.
   always @(posedge clock) begin
      if (hist_rd_en) hist_rd_data <= hist_mem[hist_rd_addr];
      if (hist_wr_en) hist_mem[hist_wr_addr] <= hist_wr_data;
      if (cdf_wr_en)  cdf_mem[cdf_wr_addr]   <= cdf_wr_data;
   end

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // mode: 0 uniform, 1 sparse, 2 all-zero, 3 random, 4 saturating
   task automatic fill_bank(input bit bank, input int mode);
      int lead;
      lead = $urandom_range(0, 50);
      for (int k = 0; k < BINS; k++) begin
         case (mode)
            0: hist_mem[{bank, 8'(k)}] = 20'd1200;
            1: hist_mem[{bank, 8'(k)}] = (k == 10) ? 20'd5 : ((k == 200) ? 20'd307195 : 20'd0);
            2: hist_mem[{bank, 8'(k)}] = 20'd0;
            3: hist_mem[{bank, 8'(k)}] = (k < lead || $urandom_range(0, 3) == 0) ? 20'd0
                                         : 20'($urandom_range(1, 3000));
            default: hist_mem[{bank, 8'(k)}] = 20'($urandom_range(0, 20'hFFFFF));
         endcase
      end
   endtask

   task automatic run_cdf(input bit bank, input bit toggle, input bit drop_early);
      longint        exp_cdf [BINS];
      longint        exp_min, s;
      logic [HW-1:0] oth_h [BINS];
      logic [HW-1:0] oth_c [BINS];
      int lat, nval, bad, changed, nz;
      bit got;
      s = 0; exp_min = 0;
      for (int k = 0; k < BINS; k++) begin
         s = s + longint'(hist_mem[{bank, 8'(k)}]);
         exp_cdf[k] = (s > SAT) ? SAT : s;
         if (exp_min == 0 && exp_cdf[k] != 0) exp_min = exp_cdf[k];
         oth_h[k] = hist_mem[{~bank, 8'(k)}];
         oth_c[k] = cdf_mem[{~bank, 8'(k)}];
      end
      @(negedge clock);
      cdf_start = 1'b1; base_offset = bank;
      lat = 0; nval = 0; bad = 0; got = 1'b0;
      while (lat < 400 && !got) begin
         @(negedge clock);
         lat++;
         if (lat == 1) check_eq("done_clear", cdf_done, 0);
         if ((hist_rd_en && hist_rd_addr[8] != bank) || (hist_wr_en && hist_wr_addr[8] != bank) ||
             (cdf_wr_en && cdf_wr_addr[8] != bank) || (hist_wr_en && hist_wr_data != 0)) bad++;
         if (toggle && lat == 60) base_offset = ~bank;
         if (drop_early && lat == 20) cdf_start = 1'b0;
         if (cdf_valid) begin got = 1'b1; nval++; end
      end
      check_eq("latency", lat, 258);
      check_eq("done_at_valid", cdf_done, 1);
      check_eq("cdf_min", Cdf_Min, exp_min);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (cdf_valid) nval++;
      end
      check_eq("done_held_start", cdf_done, 1);
      cdf_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (cdf_valid) nval++;
      end
      check_eq("done_sticky", cdf_done, 1);
      check_eq("min_hold", Cdf_Min, exp_min);
      check_eq("valid_pulses", nval, 1);
      check_eq("bank_addr", bad, 0);
      changed = 0; nz = 0;
      for (int k = 0; k < BINS; k++) begin
         check_eq($sformatf("cdf[%0d]", k), cdf_mem[{bank, 8'(k)}], exp_cdf[k]);
         if (hist_mem[{bank, 8'(k)}] != 0) nz++;
         if (hist_mem[{~bank, 8'(k)}] != oth_h[k] || cdf_mem[{~bank, 8'(k)}] != oth_c[k]) changed++;
      end
      check_eq("hist_cleared", nz, 0);
      check_eq("other_bank", changed, 0);
      base_offset = 1'b0;
   endtask

   initial begin
      bit b;
      reset = 1'b1; cdf_start = 1'b0; base_offset = 1'b0;
      for (int a = 0; a < 512; a++) begin
         hist_mem[a] = 20'($urandom_range(0, 1000));
         cdf_mem[a]  = 20'($urandom_range(0, 1000));
      end
      repeat (3) @(negedge clock);
      check_eq("rst_outputs", (|{hist_rd_en, hist_rd_addr, hist_wr_en, hist_wr_addr, hist_wr_data,
               cdf_wr_en, cdf_wr_addr, cdf_wr_data, Cdf_Min, cdf_valid, cdf_done}) ? 1 : 0, 0);
      reset = 1'b0;
      @(negedge clock);

      fill_bank(1'b0, 0); run_cdf(1'b0, 1'b0, 1'b0);
      fill_bank(1'b0, 1); run_cdf(1'b0, 1'b0, 1'b0);
      fill_bank(1'b0, 2); run_cdf(1'b0, 1'b0, 1'b0);
      fill_bank(1'b1, 3); run_cdf(1'b1, 1'b1, 1'b0);
      fill_bank(1'b0, 3); run_cdf(1'b0, 1'b0, 1'b1);
      fill_bank(1'b1, 4); run_cdf(1'b1, 1'b0, 1'b0);
      for (int r = 0; r < 3; r++) begin
         b = 1'($urandom_range(0, 1));
         fill_bank(b, 3);
         run_cdf(b, 1'($urandom_range(0, 1)), 1'b0);
      end

      // Abort a run with reset partway through, then confirm a clean rerun.
      fill_bank(1'b0, 3);
      @(negedge clock);
      cdf_start = 1'b1;
      repeat (100) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_eq("abort_outputs", (|{hist_rd_en, hist_rd_addr, hist_wr_en, hist_wr_addr, hist_wr_data,
               cdf_wr_en, cdf_wr_addr, cdf_wr_data, Cdf_Min, cdf_valid, cdf_done}) ? 1 : 0, 0);
      reset = 1'b0; cdf_start = 1'b0;
      repeat (2) @(negedge clock);
      fill_bank(1'b0, 3); run_cdf(1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
